axi4s_wrr_arbiter: RTL and testbench

Packet-level weighted round-robin arbiter sharing one AXI4-S slave between nr_of_streams_p masters.
- Grants whole packets, from first beat through tlast. A configurable per-stream weight sets how many consecutive packets a stream may send before priority rotates.
- Tags every output beat with the source id (tid).
- Has one registered output stage with full tready back-pressure.
- Sits in front of shared stream consumers (DMA, FIFO, serializer) in place of the simple beat-level round-robin mux.

---
 rtl/axi4s_arb_pkg.sv | 14 +
 rtl/axi4s_rr_picker.sv | 29 ++
 rtl/axi4s_wrr_arbiter.sv | 136 +++++++++++++
 tb/tb_axi4s_wrr_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_arb_pkg.sv
// Shared types and helpers for the packet-level WRR AXI4-S arbiter.
package axi4s_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Circular increment over 0..n-1.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/axi4s_rr_picker.sv
// Combinational circular first-set-bit search starting at i_ptr.
module axi4s_rr_picker #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic         o_vld,
   output logic [W-1:0] o_idx
);

   int w_j;

   // Scan offsets high to low so the smallest offset from i_ptr wins.
   always_comb begin
      o_vld = 1'b0;
      o_idx = '0;
      w_j   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         w_j = int'(i_ptr) + i;
         if (w_j >= N) w_j = w_j - N;
         if (i_req[w_j]) begin
            o_vld = 1'b1;
            o_idx = W'(w_j);
         end
      end
   end

endmodule

// File: rtl/axi4s_wrr_arbiter.sv
// Packet-level weighted round-robin AXI4-S arbiter with one registered output stage.
// Optional per-stream packet counters: define AXI4S_ARB_PKT_CNT_EN.
module axi4s_wrr_arbiter
   import axi4s_arb_pkg::*;
#(
   parameter int nr_of_streams_p = 4,
   parameter int tdata_width_p   = 32,
   parameter int tid_bit_width_p = $clog2(nr_of_streams_p),
   parameter int weight_width_p  = 4
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic [nr_of_streams_p-1:0][weight_width_p-1:0]   cfg_weight,
   output logic [nr_of_streams_p-1:0]                       axi4s_i_tready,
   input  logic [nr_of_streams_p-1:0]                       axi4s_i_tvalid,
   input  logic [nr_of_streams_p-1:0]                       axi4s_i_tlast,
   input  logic [nr_of_streams_p-1:0][tdata_width_p-1:0]    axi4s_i_tdata,
   input  logic                                             axi4s_o_tready,
   output logic                                             axi4s_o_tvalid,
   output logic                                             axi4s_o_tlast,
   output logic [tid_bit_width_p-1:0]                       axi4s_o_tid,
   output logic [tdata_width_p-1:0]                         axi4s_o_tdata,
`ifdef AXI4S_ARB_PKT_CNT_EN
   output logic [nr_of_streams_p-1:0][15:0]                 arb_pkt_cnt,
`endif
   output logic                                             arb_busy,
   output logic [tid_bit_width_p-1:0]                       arb_grant_id
);

   localparam int N  = nr_of_streams_p;
   localparam int TW = tid_bit_width_p;
   localparam int WW = weight_width_p;

   arb_state_t                r_state;
   logic [TW-1:0]             r_grant;
   logic [TW-1:0]             r_ptr;
   logic [WW-1:0]             r_credit;
   logic                      r_o_tvalid;
   logic                      r_o_tlast;
   logic [TW-1:0]             r_o_tid;
   logic [tdata_width_p-1:0]  r_o_tdata;

   logic                      w_pick_vld;
   logic [TW-1:0]             w_pick_idx;
   logic                      w_rdy;
   logic                      w_acc;
   logic                      w_acc_last;
   logic [WW-1:0]             w_wsel;
   logic [WW-1:0]             w_wload;

   axi4s_rr_picker #(.N(N), .W(TW)) u_picker (
      .i_req (axi4s_i_tvalid),
      .i_ptr (r_ptr),
      .o_vld (w_pick_vld),
      .o_idx (w_pick_idx)
   );

   assign w_rdy      = !r_o_tvalid || axi4s_o_tready;
   assign w_acc      = (r_state == XFER) && axi4s_i_tvalid[r_grant] && w_rdy;
   assign w_acc_last = w_acc && axi4s_i_tlast[r_grant];
   assign w_wsel     = cfg_weight[w_pick_idx];
   // A weight of 0 behaves as 1 packet per turn.
   assign w_wload    = (w_wsel == '0) ? '0 : w_wsel - WW'(1);

   always_comb begin
      axi4s_i_tready = '0;
      if (r_state == XFER) axi4s_i_tready[r_grant] = w_rdy;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_ptr    <= '0;
         r_credit <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_vld) begin
                  r_state <= XFER;
                  r_grant <= w_pick_idx;
                  if (w_pick_idx == r_grant && r_credit != '0) r_credit <= r_credit - WW'(1);
                  else                                        r_credit <= w_wload;
               end
            end
            XFER: begin
               if (w_acc_last) begin
                  r_state <= IDLE;
                  // Keep priority while credit remains; otherwise rotate past the grantee.
                  r_ptr   <= (r_credit == '0) ? TW'(wrap_inc(int'(r_grant), N)) : r_grant;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_o_tvalid <= 1'b0;
         r_o_tlast  <= 1'b0;
         r_o_tid    <= '0;
         r_o_tdata  <= '0;
      end else if (w_acc) begin
         r_o_tvalid <= 1'b1;
         r_o_tlast  <= axi4s_i_tlast[r_grant];
         r_o_tid    <= r_grant;
         r_o_tdata  <= axi4s_i_tdata[r_grant];
      end else if (axi4s_o_tready) begin
         r_o_tvalid <= 1'b0;
      end
   end

`ifdef AXI4S_ARB_PKT_CNT_EN
   logic [N-1:0][15:0] r_pkt_cnt;

   for (genvar g = 0; g < N; g++) begin : g_cnt
      always_ff @(posedge clk) begin
         if (!rst_n)
            r_pkt_cnt[g] <= '0;
         else if (w_acc_last && r_grant == TW'(g) && r_pkt_cnt[g] != 16'hFFFF)
            r_pkt_cnt[g] <= r_pkt_cnt[g] + 16'd1;
      end
   end

   assign arb_pkt_cnt = r_pkt_cnt;
`endif

   assign axi4s_o_tvalid = r_o_tvalid;
   assign axi4s_o_tlast  = r_o_tlast;
   assign axi4s_o_tid    = r_o_tid;
   assign axi4s_o_tdata  = r_o_tdata;
   assign arb_busy       = (r_state == XFER);
   assign arb_grant_id   = r_grant;

endmodule

// File: tb/tb_axi4s_wrr_arbiter.sv
// Directed bench for axi4s_wrr_arbiter: per-stream packet sources, tid sequence and data scoreboard.
module tb_axi4s_wrr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int WW = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N-1:0][WW-1:0]   cfg_weight;
   logic [N-1:0]           i_tready, i_tvalid, i_tlast;
   logic [N-1:0][DW-1:0]   i_tdata;
   logic                   o_tready;
   logic                   o_tvalid, o_tlast;
   logic [TW-1:0]          o_tid;
   logic [DW-1:0]          o_tdata;
   logic                   busy;
   logic [TW-1:0]          gnt;
`ifdef AXI4S_ARB_PKT_CNT_EN
   logic [N-1:0][15:0]     pkt_cnt;
`endif

   axi4s_wrr_arbiter #(.nr_of_streams_p(N), .tdata_width_p(DW), .tid_bit_width_p(TW),
                       .weight_width_p(WW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_weight(cfg_weight),
      .axi4s_i_tready(i_tready), .axi4s_i_tvalid(i_tvalid), .axi4s_i_tlast(i_tlast),
      .axi4s_i_tdata(i_tdata), .axi4s_o_tready(o_tready), .axi4s_o_tvalid(o_tvalid),
      .axi4s_o_tlast(o_tlast), .axi4s_o_tid(o_tid), .axi4s_o_tdata(o_tdata),
`ifdef AXI4S_ARB_PKT_CNT_EN
      .arb_pkt_cnt(pkt_cnt),
`endif
      .arb_busy(busy), .arb_grant_id(gnt)
   );

   always #5 clk = ~clk;

   int n_tot = 0, n_bad = 0, cyc = 0;
   int plen[N], pleft[N], pnum[N], bnum[N], opn[N], obn[N];
   bit stall[N];
   bit hold_chk, ostall_chk, rdy_chk;
   int cap_tid[$], cap_cyc[$], exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat(input int s, input int p, input int b);
      return {8'(s), 8'(p), 16'(b)};
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         i_tvalid[i] = (pleft[i] > 0) && !stall[i];
         i_tdata[i]  = beat(i, pnum[i], bnum[i]);
         i_tlast[i]  = (bnum[i] == plen[i] - 1);
      end
   endtask

   // One cycle: observe at negedge, advance sources just after posedge.
   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = i_tvalid & i_tready;
      if (rdy_chk) begin
         chk("rdy_onehot", 32'($countones(i_tready) <= 1), 32'd1);
         chk("rdy_other", 32'(i_tready & 4'b1010), 32'd0);
      end
      if (hold_chk) begin
         chk("hold_rdy1", 32'(i_tready[1]), 32'd0);
         chk("hold_gnt", 32'(gnt), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      if (ostall_chk) begin
         chk("ostall_vld", 32'(o_tvalid), 32'd1);
         chk("ostall_data", o_tdata, beat(2, 0, 2));
         chk("ostall_tid", 32'(o_tid), 32'd2);
         chk("ostall_last", 32'(o_tlast), 32'd0);
         chk("ostall_rdy", 32'(i_tready[2]), 32'd0);
      end
      if (o_tvalid && o_tready) begin
         int t;
         t = int'(o_tid);
         cap_tid.push_back(t);
         cap_cyc.push_back(cyc);
         chk("data", o_tdata, beat(t, opn[t], obn[t]));
         chk("last", 32'(o_tlast), 32'(obn[t] == plen[t] - 1));
         if (obn[t] == plen[t] - 1) begin obn[t] = 0; opn[t]++; end
         else obn[t]++;
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            if (bnum[i] == plen[i] - 1) begin bnum[i] = 0; pnum[i]++; pleft[i]--; end
            else bnum[i]++;
         end
      end
      drive();
   endtask

   // Reset held across one edge; outputs must all be zero afterwards.
   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         pleft[i] = 0; pnum[i] = 0; bnum[i] = 0; opn[i] = 0; obn[i] = 0; stall[i] = 0;
      end
      hold_chk = 0; ostall_chk = 0; rdy_chk = 0;
      o_tready = 1'b1;
      drive();
      cap_tid.delete(); cap_cyc.delete(); exp_q.delete();
      @(posedge clk); #1;
      chk("rst_ovld", 32'(o_tvalid), 32'd0);
      chk("rst_olast", 32'(o_tlast), 32'd0);
      chk("rst_otid", 32'(o_tid), 32'd0);
      chk("rst_odata", o_tdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rdy", 32'(i_tready), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic run_until(input int n);
      int b;
      b = 0;
      while (cap_tid.size() < n && b < 500) begin step(); b++; end
      if (b >= 500) chk("timeout", 32'(cap_tid.size()), 32'(n));
      repeat (6) step();
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_nbeats"}, 32'(cap_tid.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_tid.size(); i++)
         chk($sformatf("%s_tid%0d", tag, i), 32'(cap_tid[i]), 32'(exp_q[i]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: no finish");
      $fatal(1);
   end

   initial begin
      int b;
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < N; i++) plen[i] = 1;
      #1;
      do_reset();

      // Weights 1, streams 0 and 2 alternate 3-beat packets with one bubble.
      for (int i = 0; i < N; i++) plen[i] = 3;
      do_reset();
      pleft[0] = 3; pleft[2] = 3; rdy_chk = 1; drive();
      exp_q = '{0,0,0,2,2,2,0,0,0,2,2,2,0,0,0,2,2,2};
      run_until(18);
      rdy_chk = 0;
      check_seq("alt");
      for (int i = 1; i < cap_cyc.size(); i++)
         chk($sformatf("gap%0d", i), 32'(cap_cyc[i] - cap_cyc[i-1]), (i % 3 == 0) ? 32'd2 : 32'd1);
`ifdef AXI4S_ARB_PKT_CNT_EN
      chk("pktcnt0", 32'(pkt_cnt[0]), 32'd3);
      chk("pktcnt2", 32'(pkt_cnt[2]), 32'd3);
      chk("pktcnt1", 32'(pkt_cnt[1]), 32'd0);
`endif

      // Weight 3 on stream 1, 1 on stream 3, single-beat packets.
      cfg_weight = {4'd1, 4'd1, 4'd3, 4'd1};
      for (int i = 0; i < N; i++) plen[i] = 1;
      do_reset();
      pleft[1] = 6; pleft[3] = 2; drive();
      exp_q = '{1,1,1,3,1,1,1,3};
      run_until(8);
      check_seq("wrr");

      // Stream 0 stalls mid-packet; grant must hold.
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      plen[0] = 4; plen[1] = 1;
      do_reset();
      pleft[0] = 1; pleft[1] = 1; drive();
      b = 0;
      while (bnum[0] < 2 && b < 100) begin step(); b++; end
      if (b >= 100) chk("timeout_s0", 32'(bnum[0]), 32'd2);
      stall[0] = 1; drive();
      hold_chk = 1;
      repeat (5) step();
      hold_chk = 0; stall[0] = 0; drive();
      exp_q = '{0,0,0,0,1};
      run_until(5);
      check_seq("hold");

      // Downstream back-pressure for 4 cycles mid-packet.
      for (int i = 0; i < N; i++) plen[i] = 6;
      do_reset();
      pleft[2] = 1; drive();
      b = 0;
      while (cap_tid.size() < 2 && b < 100) begin step(); b++; end
      if (b >= 100) chk("timeout_bp", 32'(cap_tid.size()), 32'd2);
      o_tready = 1'b0;
      ostall_chk = 1;
      repeat (4) step();
      ostall_chk = 0; o_tready = 1'b1;
      exp_q = '{2,2,2,2,2,2};
      run_until(6);
      check_seq("bp");

      // Weight 0 acts as 1.
      cfg_weight = {4'd1, 4'd0, 4'd1, 4'd1};
      for (int i = 0; i < N; i++) plen[i] = 1;
      do_reset();
      pleft[2] = 2; pleft[3] = 2; drive();
      exp_q = '{2,3,2,3};
      run_until(4);
      check_seq("w0");

      // Reset mid-packet, then a clean restart from ptr 0.
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < N; i++) plen[i] = 4;
      do_reset();
      pleft[0] = 1; drive();
      b = 0;
      while (cap_tid.size() < 2 && b < 100) begin step(); b++; end
      if (b >= 100) chk("timeout_rst", 32'(cap_tid.size()), 32'd2);
      for (int i = 0; i < N; i++) plen[i] = 2;
      do_reset();
      pleft[1] = 1; pleft[3] = 1; drive();
      exp_q = '{1,1,3,3};
      run_until(4);
      check_seq("rst");

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
